// File: rtl/psd_sdivide.sv
// psd_sdivide: sequential signed divider, one restoring step per clock, DW+1 cycle latency.
// Ports: clock, reset (async low); start/dividend/divisor in; busy, done, quotient, rest, divzero, overflow out.
module psd_sdivide #(
  parameter int DW             = 32,
  parameter int VW             = 16,
  parameter int SIGNED_DIVISOR = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW:0]   rest,
  output logic          divzero,
  output logic          overflow
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] r_q;
  logic [VW-1:0] b_q;
  logic          a_neg_q;
  logic          b_neg_q;
  logic          dz_q;
  logic          ov_q;

  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic          b_zero;
  logic          ovf_in;

  logic [VW:0]   shifted;
  logic          ge;
  logic [VW-1:0] rem_sub;
  logic [DW-1:0] q_res;
  logic [VW:0]   r_res;

  // Operand magnitudes: unsigned widths DW/VW hold the
  // negated most-negative value exactly.
  always_comb begin
    a_neg  = dividend[DW-1];
    b_neg  = (SIGNED_DIVISOR != 0) && divisor[VW-1];
    a_mag  = a_neg ? ({DW{1'b0}} - dividend) : dividend;
    b_mag  = b_neg ? ({VW{1'b0}} - divisor) : divisor;
    b_zero = (divisor == '0);
    ovf_in = (SIGNED_DIVISOR != 0)
           && (dividend == {1'b1, {(DW-1){1'b0}}})
           && (divisor == '1);
  end

  // Restoring step: partial remainder < 2*b, so the
  // difference always fits back into VW bits.
  always_comb begin
    shifted = {r_q, q_q[DW-1]};
    ge      = (shifted >= {1'b0, b_q});
    rem_sub = shifted[VW-1:0] - b_q;
    q_res   = (a_neg_q ^ b_neg_q) ? ({DW{1'b0}} - q_q) : q_q;
    r_res   = a_neg_q ? ({(VW+1){1'b0}} - {1'b0, r_q})
                      : {1'b0, r_q};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CW'(DW - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      b_q      <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      rest     <= '0;
      divzero  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            q_q     <= a_mag;
            r_q     <= '0;
            b_q     <= b_mag;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            dz_q    <= b_zero;
            ov_q    <= ovf_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          q_q   <= {q_q[DW-2:0], ge};
          r_q   <= ge ? rem_sub : shifted[VW-1:0];
          cnt_q <= cnt_q + CW'(1);
        end
        FINISH: begin
          quotient <= dz_q ? '0 : q_res;
          rest     <= dz_q ? '0 : r_res;
          divzero  <= dz_q;
          overflow <= ov_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psd_sdivide.sv
// tb_psd_sdivide: directed self-checking bench for psd_sdivide.
// Signed-divisor instance dut plus unsigned-divisor instance dut_u.
module tb_psd_sdivide;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_s = 1'b0;
  logic        start_u = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;

  logic        busy_s, done_s, dz_s, ov_s;
  logic [31:0] q_s;
  logic [16:0] r_s;
  logic        busy_u, done_u, dz_u, ov_u;
  logic [31:0] q_u;
  logic [16:0] r_u;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  psd_sdivide #(.DW(32), .VW(16), .SIGNED_DIVISOR(1)) dut (
    .clock(clock), .reset(reset), .start(start_s),
    .dividend(dividend), .divisor(divisor),
    .busy(busy_s), .done(done_s), .quotient(q_s), .rest(r_s),
    .divzero(dz_s), .overflow(ov_s)
  );

  psd_sdivide #(.DW(32), .VW(16), .SIGNED_DIVISOR(0)) dut_u (
    .clock(clock), .reset(reset), .start(start_u),
    .dividend(dividend), .divisor(divisor),
    .busy(busy_u), .done(done_u), .quotient(q_u), .rest(r_u),
    .divzero(dz_u), .overflow(ov_u)
  );

  // Runs one division; lat = edges from accept to done (-1 on timeout),
  // bcnt = busy samples seen between accept and done.
  task automatic do_div(input logic [31:0] a, input logic [15:0] b,
                        input bit uns,
                        output logic [31:0] q, output logic [16:0] r,
                        output logic dz, output logic ov,
                        output int lat, output int bcnt);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    if (uns) start_u = 1'b1;
    else start_s = 1'b1;
    @(posedge clock);
    #1;
    start_s = 1'b0;
    start_u = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (uns ? busy_u : busy_s) bcnt++;
      if (i > 0 && (uns ? done_u : done_s)) begin
        lat = i;
        break;
      end
      @(posedge clock);
      #1;
    end
    q  = uns ? q_u : q_s;
    r  = uns ? r_u : r_s;
    dz = uns ? dz_u : dz_s;
    ov = uns ? ov_u : ov_s;
  endtask

  task automatic test_reset();
    int lat;
    #3 reset = 1'b0;
    #1;
    tests++;
    if ({busy_s, done_s, q_s, r_s, dz_s, ov_s} !== '0) begin
      fails++;
      $display("FAIL reset_state got q=%h r=%h b=%b d=%b want all 0",
               q_s, r_s, busy_s, done_s);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset    = 1'b1;
    dividend = 32'd10;
    divisor  = 16'd3;
    start_s  = 1'b1;
    @(posedge clock);
    #1;
    start_s = 1'b0;
    tests++;
    if (busy_s !== 1'b1) begin
      fails++;
      $display("FAIL first_edge_accept got busy=%b want 1", busy_s);
    end
    lat = -1;
    for (int i = 1; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (done_s) begin lat = i; break; end
    end
    tests++;
    if (lat != 33 || q_s !== 32'd3 || r_s !== 17'd1) begin
      fails++;
      $display("FAIL first_div got lat=%0d q=%h r=%h want 33 3 1",
               lat, q_s, r_s);
    end
  endtask

  task automatic test_basic();
    logic [31:0] q; logic [16:0] r; logic dz, ov; int lat, bc;
    do_div(32'd1000, 16'd7, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (lat != 33) begin
      fails++; $display("FAIL basic_lat got %0d want 33", lat);
    end
    tests++;
    if (bc != 32) begin
      fails++; $display("FAIL basic_busy got %0d want 32", bc);
    end
    tests++;
    if (q !== 32'd142 || r !== 17'd6) begin
      fails++; $display("FAIL basic_qr got q=%h r=%h want 8e 6", q, r);
    end
    tests++;
    if ({dz, ov} !== 2'b00) begin
      fails++; $display("FAIL basic_flags got %b want 00", {dz, ov});
    end
  endtask

  task automatic test_signs();
    logic [31:0] q; logic [16:0] r; logic dz, ov; int lat, bc;
    do_div(32'hFFFF_FC18, 16'd7, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'hFFFF_FF72 || r !== 17'h1FFFA) begin
      fails++; $display("FAIL neg_pos got q=%h r=%h want ffffff72 1fffa", q, r);
    end
    do_div(32'd1000, 16'hFFF9, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'hFFFF_FF72 || r !== 17'd6) begin
      fails++; $display("FAIL pos_neg got q=%h r=%h want ffffff72 6", q, r);
    end
    do_div(32'hFFFF_FC18, 16'hFFF9, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'd142 || r !== 17'h1FFFA) begin
      fails++; $display("FAIL neg_neg got q=%h r=%h want 8e 1fffa", q, r);
    end
    do_div(32'd1000, 16'hFFF9, 1'b1, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'd0 || r !== 17'd1000 || lat != 33) begin
      fails++;
      $display("FAIL unsigned_div got q=%h r=%h lat=%0d want 0 3e8 33",
               q, r, lat);
    end
  endtask

  task automatic test_divzero();
    logic [31:0] q; logic [16:0] r; logic dz, ov; int lat, bc;
    do_div(32'd12345, 16'd0, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'd0 || r !== 17'd0 || dz !== 1'b1 || ov !== 1'b0) begin
      fails++;
      $display("FAIL divzero got q=%h r=%h dz=%b ov=%b want 0 0 1 0",
               q, r, dz, ov);
    end
    tests++;
    if (lat != 33) begin
      fails++; $display("FAIL divzero_lat got %0d want 33", lat);
    end
    do_div(32'd10, 16'd3, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'd3 || r !== 17'd1 || dz !== 1'b0) begin
      fails++;
      $display("FAIL after_divzero got q=%h r=%h dz=%b want 3 1 0", q, r, dz);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q; logic [16:0] r; logic dz, ov; int lat, bc;
    do_div(32'h8000_0000, 16'hFFFF, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'h8000_0000 || r !== 17'd0 || ov !== 1'b1 || dz !== 1'b0) begin
      fails++;
      $display("FAIL ovf got q=%h r=%h ov=%b dz=%b want 80000000 0 1 0",
               q, r, ov, dz);
    end
    do_div(32'h8000_0000, 16'h8000, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (q !== 32'd65536 || r !== 17'd0 || ov !== 1'b0) begin
      fails++;
      $display("FAIL min_min got q=%h r=%h ov=%b want 10000 0 0", q, r, ov);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 16'd9;
    start_s  = 1'b1;
    @(posedge clock);
    #1;
    start_s = 1'b0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (i == 5 || i == 20) begin
        dividend = 32'd5;
        divisor  = 16'd1;
        start_s  = 1'b1;
      end else begin
        start_s = 1'b0;
      end
      if (i == 15) begin
        tests++;
        if (q_s !== 32'd65536) begin
          fails++; $display("FAIL hold_q got %h want 10000", q_s);
        end
      end
      if (i > 0 && done_s) begin lat = i; break; end
      @(posedge clock);
      #1;
    end
    start_s = 1'b0;
    tests++;
    if (lat != 33 || q_s !== 32'd11 || r_s !== 17'd1) begin
      fails++;
      $display("FAIL ignore_start got lat=%0d q=%h r=%h want 33 b 1",
               lat, q_s, r_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q; logic [16:0] r; logic dz, ov; int lat, bc;
    time t0;
    do_div(32'd100, 16'd9, 1'b0, q, r, dz, ov, lat, bc);
    t0 = $time;
    do_div(32'd1000, 16'hFFF9, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (($time - t0) != 340 || lat != 33) begin
      fails++;
      $display("FAIL b2b_timing got dt=%0t lat=%0d want 340 33",
               $time - t0, lat);
    end
    tests++;
    if (q !== 32'hFFFF_FF72 || r !== 17'd6) begin
      fails++; $display("FAIL b2b_result got q=%h r=%h want ffffff72 6", q, r);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] q; logic [16:0] r; logic dz, ov; int lat, bc;
    bit seen;
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 16'd9;
    start_s  = 1'b1;
    @(posedge clock);
    #1;
    start_s = 1'b0;
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({busy_s, done_s, q_s, r_s, dz_s, ov_s} !== '0) begin
      fails++;
      $display("FAIL abort_state got q=%h r=%h b=%b d=%b want all 0",
               q_s, r_s, busy_s, done_s);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done_s) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL abort_no_done got done seen=%b want 0", seen);
    end
    do_div(32'd10, 16'd3, 1'b0, q, r, dz, ov, lat, bc);
    tests++;
    if (lat != 33 || q !== 32'd3 || r !== 17'd1) begin
      fails++;
      $display("FAIL after_abort got lat=%0d q=%h r=%h want 33 3 1",
               lat, q, r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_divzero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
